// File: rtl/hazard_forward_unit.sv
// Hazard detection and EXE-stage forwarding-select generator for the 5-stage pipeline.
// Compares ID source operands against EXE/MEM destinations and keeps saturating stall statistics.
module hazard_forward_unit #(
    parameter int REG_AW = 4,
    parameter int NSRC   = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     forward_en,
    input  logic                     freeze,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [NSRC*REG_AW-1:0]   src,
    input  logic                     exe_wb_en,
    input  logic                     exe_mem_r_en,
    input  logic [REG_AW-1:0]        exe_dest,
    input  logic                     mem_wb_en,
    input  logic [REG_AW-1:0]        mem_dest,
    input  logic                     stat_clr,
    output logic                     hazard_detected,
    output logic [2*NSRC-1:0]        fwd_sel,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         hazard_events
);

    localparam logic [1:0]       SEL_RF  = 2'b00;
    localparam logic [1:0]       SEL_MEM = 2'b01;
    localparam logic [1:0]       SEL_WB  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NSRC-1:0]   w_match_exe;
    logic [NSRC-1:0]   w_match_mem;
    logic [2*NSRC-1:0] w_next_sel;
    logic              w_hazard;

    logic [2*NSRC-1:0] r_fwd_sel;
    logic              r_hazard_q;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_hazard_events;

    always_comb begin
        w_match_exe = '0;
        w_match_mem = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_match_exe[i] = src_valid[i] & exe_wb_en & (src[i*REG_AW +: REG_AW] == exe_dest);
            w_match_mem[i] = src_valid[i] & mem_wb_en & (src[i*REG_AW +: REG_AW] == mem_dest);
        end
    end

    // With forwarding only a load in EXE cannot be bypassed; without it any pending write stalls.
    always_comb begin
        w_hazard = 1'b0;
        if (forward_en) begin
            w_hazard = |(w_match_exe & {NSRC{exe_mem_r_en}});
        end else begin
            w_hazard = |(w_match_exe | w_match_mem);
        end
    end

    // EXE producer is younger than MEM producer, so it wins when both match.
    always_comb begin
        w_next_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (!forward_en) begin
                w_next_sel[2*i +: 2] = SEL_RF;
            end else if (w_match_exe[i]) begin
                w_next_sel[2*i +: 2] = SEL_MEM;
            end else if (w_match_mem[i]) begin
                w_next_sel[2*i +: 2] = SEL_WB;
            end else begin
                w_next_sel[2*i +: 2] = SEL_RF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_sel  <= '0;
            r_hazard_q <= 1'b0;
        end else if (!freeze) begin
            r_fwd_sel  <= w_hazard ? '0 : w_next_sel;
            r_hazard_q <= w_hazard;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles  <= '0;
            r_hazard_events <= '0;
        end else if (!freeze) begin
            if (stat_clr) begin
                r_stall_cycles  <= '0;
                r_hazard_events <= '0;
            end else if (w_hazard) begin
                if (r_stall_cycles != CNT_MAX) begin
                    r_stall_cycles <= r_stall_cycles + CNT_ONE;
                end
                if (!r_hazard_q && (r_hazard_events != CNT_MAX)) begin
                    r_hazard_events <= r_hazard_events + CNT_ONE;
                end
            end
        end
    end

    assign hazard_detected = w_hazard;
    assign fwd_sel         = r_fwd_sel;
    assign stall_cycles    = r_stall_cycles;
    assign hazard_events   = r_hazard_events;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed steps plus random traffic against a behavioural model.
// Two instances share inputs; the narrow-counter one exercises saturation.
module tb_hazard_forward_unit;

    localparam int AW = 4;
    localparam int NS = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            forward_en;
    logic            freeze;
    logic [NS-1:0]   src_valid;
    logic [NS*AW-1:0] src;
    logic            exe_wb_en;
    logic            exe_mem_r_en;
    logic [AW-1:0]   exe_dest;
    logic            mem_wb_en;
    logic [AW-1:0]   mem_dest;
    logic            stat_clr;

    logic            haz_a, haz_b;
    logic [2*NS-1:0] fwd_a, fwd_b;
    logic [15:0]     stall_a, events_a;
    logic [3:0]      stall_b, events_b;

    int n_pass  = 0;
    int n_total = 0;

    // Model state
    int exp_fwd;
    int exp_stall16, exp_events16, exp_stall4, exp_events4;
    bit exp_hq;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(AW), .NSRC(NS), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .forward_en(forward_en), .freeze(freeze),
        .src_valid(src_valid), .src(src), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .stat_clr(stat_clr), .hazard_detected(haz_a),
        .fwd_sel(fwd_a), .stall_cycles(stall_a), .hazard_events(events_a)
    );

    hazard_forward_unit #(.REG_AW(AW), .NSRC(NS), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .forward_en(forward_en), .freeze(freeze),
        .src_valid(src_valid), .src(src), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .stat_clr(stat_clr), .hazard_detected(haz_b),
        .fwd_sel(fwd_b), .stall_cycles(stall_b), .hazard_events(events_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic int operand(input int i);
        return int'((src >> (i * AW)) & 12'hF);
    endfunction

    function automatic bit hits_exe(input int i);
        return src_valid[i] && exe_wb_en && (operand(i) == int'(exe_dest));
    endfunction

    function automatic bit hits_mem(input int i);
        return src_valid[i] && mem_wb_en && (operand(i) == int'(mem_dest));
    endfunction

    function automatic bit mdl_hazard();
        bit h = 0;
        for (int i = 0; i < NS; i++) begin
            if (forward_en) h = h || (hits_exe(i) && exe_mem_r_en);
            else            h = h || hits_exe(i) || hits_mem(i);
        end
        return h;
    endfunction

    function automatic int mdl_next_sel();
        int v = 0;
        int s;
        for (int i = 0; i < NS; i++) begin
            s = 0;
            if (forward_en) begin
                if (hits_exe(i))      s = 1;
                else if (hits_mem(i)) s = 2;
            end
            v = v + (s << (2 * i));
        end
        return v;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic mdl_reset();
        exp_fwd = 0; exp_stall16 = 0; exp_events16 = 0;
        exp_stall4 = 0; exp_events4 = 0; exp_hq = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".fwd"},      32'(fwd_a),    32'(exp_fwd));
        chk({tag, ".fwd4"},     32'(fwd_b),    32'(exp_fwd));
        chk({tag, ".stall"},    32'(stall_a),  32'(exp_stall16));
        chk({tag, ".events"},   32'(events_a), 32'(exp_events16));
        chk({tag, ".stall4"},   32'(stall_b),  32'(exp_stall4));
        chk({tag, ".events4"},  32'(events_b), 32'(exp_events4));
    endtask

    // Check combinational hazard, clock once, update model, check registers.
    task automatic step(input string tag);
        bit h;
        int ns;
        #1;
        h  = mdl_hazard();
        ns = mdl_next_sel();
        chk({tag, ".haz"},  32'(haz_a), 32'(h));
        chk({tag, ".haz4"}, 32'(haz_b), 32'(h));
        @(posedge clk);
        if (!freeze) begin
            exp_fwd = h ? 0 : ns;
            if (stat_clr) begin
                exp_stall16 = 0; exp_events16 = 0; exp_stall4 = 0; exp_events4 = 0;
            end else if (h) begin
                exp_stall16 = sat(exp_stall16 + 1, 65535);
                exp_stall4  = sat(exp_stall4 + 1, 15);
                if (!exp_hq) begin
                    exp_events16 = sat(exp_events16 + 1, 65535);
                    exp_events4  = sat(exp_events4 + 1, 15);
                end
            end
            exp_hq = h;
        end
        #1;
        chk_regs(tag);
    endtask

    task automatic idle_inputs();
        forward_en = 1'b1; freeze = 1'b0; src_valid = '0; src = '0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_dest = '0;
        mem_wb_en = 1'b0; mem_dest = '0; stat_clr = 1'b0;
    endtask

    initial begin
        mdl_reset();
        idle_inputs();
        rst_n = 1'b0;

        // Reset with active inputs; hazard output still follows inputs.
        forward_en = 1'b1; src_valid = 3'b001; src = {4'd0, 4'd0, 4'd3};
        exe_wb_en = 1'b1; exe_dest = 4'd3; exe_mem_r_en = 1'b1; stat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.haz", 32'(haz_a), 32'(mdl_hazard()));
        chk_regs("rst");
        exe_mem_r_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_release");

        // Forward from EXE, then from MEM.
        idle_inputs();
        src_valid = 3'b001; src = {4'd0, 4'd0, 4'd3}; exe_wb_en = 1'b1; exe_dest = 4'd3;
        step("fwd_exe");
        exe_wb_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd3;
        step("fwd_mem");
        exe_wb_en = 1'b1; exe_dest = 4'd3;
        step("fwd_both");

        // Load-use stall then forward from WB stage.
        idle_inputs();
        src_valid = 3'b010; src = {4'd0, 4'd5, 4'd0};
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd5;
        step("load_use");
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd5;
        step("load_after");

        // Stall-only mode.
        idle_inputs();
        forward_en = 1'b0; src_valid = 3'b100; src = {4'd7, 4'd0, 4'd0};
        mem_wb_en = 1'b1; mem_dest = 4'd7;
        step("stall_only1");
        step("stall_only2");
        src_valid = 3'b000;
        step("stall_invalid");

        // Hazard held across a freeze.
        src_valid = 3'b100; freeze = 1'b1;
        step("freeze1");
        stat_clr = 1'b1;
        step("freeze2");
        stat_clr = 1'b0;
        step("freeze3");
        freeze = 1'b0;
        step("unfreeze");

        // Saturation of the narrow counters, then clear concurrent with hazard.
        repeat (20) step("sat");
        chk("sat.stall4_max", 32'(stall_b), 32'd15);
        stat_clr = 1'b1;
        step("clr_hazard");
        stat_clr = 1'b0;
        forward_en = 1'b1;
        step("mode_switch");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            forward_en   = ($urandom_range(0, 3) != 0);
            freeze       = ($urandom_range(0, 4) == 0);
            stat_clr     = ($urandom_range(0, 24) == 0);
            src_valid    = NS'($urandom);
            for (int i = 0; i < NS; i++) src[i*AW +: AW] = AW'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom);
            exe_mem_r_en = 1'($urandom);
            exe_dest     = AW'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom);
            mem_dest     = AW'($urandom_range(0, 3));
            step("rand");
            if (n == 200) begin
                // Asynchronous reset mid-stream, between clock edges.
                #2;
                rst_n = 1'b0;
                mdl_reset();
                #1;
                chk_regs("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
